seq_decoder: RTL and testbench

SEQ_DECODER -- requirements
Module: seq_decoder

---
 rtl/seq_decoder_if.sv | 37 +++
 rtl/seq_decoder.sv | 146 ++++++++++++++
 tb/tb_seq_decoder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seq_decoder_if.sv
// seq_decoder_if -- bus bundle between a seq_decoder and whatever drives it.
//
// Signals (direction as seen by the decoder, i.e. the slave modport):
//   i_enable     in   1       master enable; low forces every output low
//   i_addr       in   ADDR_W  select / scan start address, bit 0 is the LSB
//   i_mode       in   2       00 level, 01 pulse, 10 scan, 11 behaves as level
//   i_load       in   1       start strobe for pulse and scan modes
//   o_out        out  OUTS    registered one-hot decode, o_out[k] <-> address k
//   o_busy       out  1       high while a scan is running
//   o_scan_done  out  1       one-cycle flag on the final cycle of a full scan
//
// The master modport is the stimulus side, the slave modport is the decoder.
interface seq_decoder_if #(
  parameter int ADDR_W = 2
) ();

  localparam int OUTS = 2 ** ADDR_W;

  logic              i_enable;
  logic [ADDR_W-1:0] i_addr;
  logic [1:0]        i_mode;
  logic              i_load;
  logic [OUTS-1:0]   o_out;
  logic              o_busy;
  logic              o_scan_done;

  modport master (
    output i_enable, i_addr, i_mode, i_load,
    input  o_out, o_busy, o_scan_done
  );

  modport slave (
    input  i_enable, i_addr, i_mode, i_load,
    output o_out, o_busy, o_scan_done
  );

endinterface

// File: rtl/seq_decoder.sv
// seq_decoder -- registered address decoder with level, pulse and scan modes.
//
// Ports:
//   clk      in  1   rising-edge clock
//   reset_n  in  1   synchronous active-low reset
//   bus      seq_decoder_if.slave (enable, addr, mode, load in;
//                                  out, busy, scan_done out)
//
// Parameters:
//   ADDR_W  address width (1..6), giving OUTS = 2**ADDR_W decoded outputs
//   DWELL   cycles each output is held during a scan (1..255)
//
// Every output is a flop, so nothing combinational reaches the pins. In scan
// mode the block walks all OUTS addresses starting from the captured one,
// wrapping at OUTS-1, holding each for DWELL cycles, and flags the very last
// cycle with scan_done. Dropping enable during a scan aborts it silently.
module seq_decoder #(
  parameter int ADDR_W = 2,
  parameter int DWELL  = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  seq_decoder_if.slave bus
);

  localparam int OUTS  = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(DWELL + 1);

  // Value of the dwell counter on the last cycle an output is held, and the
  // step count of the final address of a scan.
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [ADDR_W-1:0] STEP_LAST  = ADDR_W'(OUTS - 1);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t            r_state;
  logic [OUTS-1:0]   r_out;
  logic              r_busy;
  logic              r_scanDone;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_step;
  logic [CNT_W-1:0]  r_dwell;

  logic [ADDR_W-1:0] w_addrNext;
  logic [ADDR_W-1:0] w_stepNext;
  logic [CNT_W-1:0]  w_dwellNext;
  logic              w_dwellEnd;

  function automatic logic [OUTS-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [OUTS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // Scan bookkeeping: the address wraps naturally at ADDR_W bits, the step
  // counter records how many addresses have been visited so far.
  assign w_addrNext  = r_addr + ADDR_W'(1);
  assign w_stepNext  = r_step + ADDR_W'(1);
  assign w_dwellNext = r_dwell + CNT_W'(1);
  assign w_dwellEnd  = (r_dwell == DWELL_LAST);

  // Single state machine holding every output register. In IDLE the mode is
  // decoded each cycle; in SCAN only enable is looked at. scan_done is raised
  // one edge ahead, i.e. when the counters are about to enter the final dwell
  // cycle, so that it lines up with the last output; the edge that follows a
  // raised scan_done returns to IDLE with everything cleared, leaving that
  // IDLE cycle free to accept a fresh load.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_out      <= '0;
      r_busy     <= 1'b0;
      r_scanDone <= 1'b0;
      r_addr     <= '0;
      r_step     <= '0;
      r_dwell    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_busy     <= 1'b0;
          r_scanDone <= 1'b0;
          if (!bus.i_enable) begin
            r_out <= '0;
          end else begin
            case (bus.i_mode)
              2'b01: begin
                r_out <= bus.i_load ? onehot(bus.i_addr) : '0;
              end
              2'b10: begin
                if (bus.i_load) begin
                  r_state <= SCAN;
                  r_busy  <= 1'b1;
                  r_addr  <= bus.i_addr;
                  r_step  <= '0;
                  r_dwell <= '0;
                  r_out   <= onehot(bus.i_addr);
                end else begin
                  r_out <= '0;
                end
              end
              default: begin
                r_out <= onehot(bus.i_addr);
              end
            endcase
          end
        end

        SCAN: begin
          if (!bus.i_enable || r_scanDone) begin
            r_state    <= IDLE;
            r_out      <= '0;
            r_busy     <= 1'b0;
            r_scanDone <= 1'b0;
            r_addr     <= '0;
            r_step     <= '0;
            r_dwell    <= '0;
          end else if (w_dwellEnd) begin
            r_addr     <= w_addrNext;
            r_step     <= w_stepNext;
            r_dwell    <= '0;
            r_out      <= onehot(w_addrNext);
            r_scanDone <= (w_stepNext == STEP_LAST) && (DWELL_LAST == '0);
          end else begin
            r_dwell    <= w_dwellNext;
            r_scanDone <= (r_step == STEP_LAST) && (w_dwellNext == DWELL_LAST);
          end
        end

        default: begin
          r_state <= IDLE;
          r_out   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_out       = r_out;
  assign bus.o_busy      = r_busy;
  assign bus.o_scan_done = r_scanDone;

endmodule

// File: tb/tb_seq_decoder.sv
// tb_seq_decoder -- scoreboard bench for seq_decoder.
//
// Two decoders share clock and reset: dutA (ADDR_W=2, DWELL=1) and dutB
// (ADDR_W=3, DWELL=2). Each stimulus cycle drives one of them and pushes the
// outputs expected after the next rising edge; a monitor process pops one
// entry per edge and compares it against the addressed decoder.
module tb_seq_decoder;

  localparam logic [1:0] LEVEL = 2'b00;
  localparam logic [1:0] PULSE = 2'b01;
  localparam logic [1:0] SCANM = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;

  typedef struct packed {
    logic       dut;
    logic [7:0] out;
    logic       busy;
    logic       done;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset_n;
  exp_t   sbQ[$];
  string  nameQ[$];
  int     checks = 0;
  int     errors = 0;

  seq_decoder_if #(.ADDR_W(2)) busA ();
  seq_decoder_if #(.ADDR_W(3)) busB ();

  seq_decoder #(.ADDR_W(2), .DWELL(1)) dutA (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (busA)
  );

  seq_decoder #(.ADDR_W(3), .DWELL(2)) dutB (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (busB)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic logic [7:0] oh(input int a);
    return 8'b1 << a;
  endfunction

  // Drive one cycle of inputs on the falling edge and queue what the chosen
  // decoder must show after the following rising edge.
  task automatic applyStimulus(input logic dut, input logic rst, input logic en,
                               input logic [2:0] addr, input logic [1:0] mode,
                               input logic load, input logic [7:0] expOut,
                               input logic expBusy, input logic expDone,
                               input string name);
    exp_t e;
    @(negedge clk);
    reset_n = rst;
    busA.i_enable = 1'b0; busA.i_addr = '0; busA.i_mode = LEVEL; busA.i_load = 1'b0;
    busB.i_enable = 1'b0; busB.i_addr = '0; busB.i_mode = LEVEL; busB.i_load = 1'b0;
    if (!dut) begin
      busA.i_enable = en; busA.i_addr = addr[1:0]; busA.i_mode = mode; busA.i_load = load;
    end else begin
      busB.i_enable = en; busB.i_addr = addr; busB.i_mode = mode; busB.i_load = load;
    end
    e.dut  = dut;
    e.out  = expOut;
    e.busy = expBusy;
    e.done = expDone;
    sbQ.push_back(e);
    nameQ.push_back(name);
  endtask

  // Compare one scoreboard entry with the live outputs of its decoder.
  task automatic checkOutput(input exp_t e, input string name);
    logic [7:0] actOut;
    logic       actBusy;
    logic       actDone;
    if (e.dut) begin
      actOut = busB.o_out; actBusy = busB.o_busy; actDone = busB.o_scan_done;
    end else begin
      actOut = {4'b0000, busA.o_out}; actBusy = busA.o_busy; actDone = busA.o_scan_done;
    end
    checks++;
    if (actOut !== e.out || actBusy !== e.busy || actDone !== e.done) begin
      errors++;
      $display("[TB] FAIL %s: got out=%b busy=%b done=%b, expected out=%b busy=%b done=%b",
               name, actOut, actBusy, actDone, e.out, e.busy, e.done);
    end
  endtask

  // Monitor: one scoreboard entry is consumed just after every rising edge.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(e, n);
      end
    end
  end

  // Directed stimulus with hand-worked expectations.
  initial begin
    reset_n = 1'b0;
    busA.i_enable = 1'b0; busA.i_addr = '0; busA.i_mode = LEVEL; busA.i_load = 1'b0;
    busB.i_enable = 1'b0; busB.i_addr = '0; busB.i_mode = LEVEL; busB.i_load = 1'b0;

    applyStimulus(0, 0, 1, 3'd2, LEVEL, 0, 8'h00, 0, 0, "reset_a");
    applyStimulus(0, 0, 1, 3'd2, SCANM, 1, 8'h00, 0, 0, "reset_b");

    for (int a = 0; a < 4; a++)
      applyStimulus(0, 1, 0, 3'(a), LEVEL, 0, 8'h00, 0, 0, "level_en0");
    for (int a = 0; a < 4; a++)
      applyStimulus(0, 1, 1, 3'(a), LEVEL, 0, oh(a), 0, 0, "level_en1");

    applyStimulus(0, 1, 1, 3'd1, RSVD, 1, oh(1), 0, 0, "mode11_level");
    applyStimulus(0, 1, 1, 3'd3, RSVD, 1, oh(3), 0, 0, "mode11_noscan");

    applyStimulus(0, 1, 1, 3'd2, PULSE, 1, oh(2), 0, 0, "pulse_a2");
    applyStimulus(0, 1, 1, 3'd1, PULSE, 1, oh(1), 0, 0, "pulse_a1");
    applyStimulus(0, 1, 1, 3'd1, PULSE, 0, 8'h00, 0, 0, "pulse_end");
    applyStimulus(0, 1, 0, 3'd3, PULSE, 1, 8'h00, 0, 0, "pulse_en0");
    applyStimulus(0, 1, 0, 3'd2, SCANM, 1, 8'h00, 0, 0, "scan_en0_idle");

    applyStimulus(0, 1, 1, 3'd3, SCANM, 1, oh(3), 1, 0, "scanA_0");
    applyStimulus(0, 1, 1, 3'd1, LEVEL, 1, oh(0), 1, 0, "scanA_1");
    applyStimulus(0, 1, 1, 3'd2, PULSE, 0, oh(1), 1, 0, "scanA_2");
    applyStimulus(0, 1, 1, 3'd0, SCANM, 1, oh(2), 1, 1, "scanA_done");
    applyStimulus(0, 1, 1, 3'd1, SCANM, 1, 8'h00, 0, 0, "scanA_idle");
    applyStimulus(0, 1, 1, 3'd1, SCANM, 1, oh(1), 1, 0, "scanA2_0");
    applyStimulus(0, 1, 1, 3'd0, LEVEL, 0, oh(2), 1, 0, "scanA2_1");
    applyStimulus(0, 1, 1, 3'd0, LEVEL, 0, oh(3), 1, 0, "scanA2_2");
    applyStimulus(0, 1, 1, 3'd0, LEVEL, 0, oh(0), 1, 1, "scanA2_done");
    applyStimulus(0, 1, 1, 3'd2, LEVEL, 0, 8'h00, 0, 0, "scanA2_idle");
    applyStimulus(0, 1, 1, 3'd2, LEVEL, 0, oh(2), 0, 0, "after_scan_level");

    applyStimulus(0, 1, 1, 3'd0, SCANM, 1, oh(0), 1, 0, "rstscan_0");
    applyStimulus(0, 1, 1, 3'd0, LEVEL, 0, oh(1), 1, 0, "rstscan_1");
    applyStimulus(0, 1, 1, 3'd0, LEVEL, 0, oh(2), 1, 0, "rstscan_2");
    applyStimulus(0, 0, 1, 3'd0, LEVEL, 0, 8'h00, 0, 0, "rstscan_reset");
    applyStimulus(0, 1, 1, 3'd1, LEVEL, 0, oh(1), 0, 0, "post_reset_level");

    for (int i = 0; i < 16; i++)
      applyStimulus(1, 1, 1, 3'(i == 0 ? 6 : 0), (i == 0) ? SCANM : LEVEL, (i == 0),
                    oh((6 + i / 2) % 8), 1, (i == 15), "scanB");
    applyStimulus(1, 1, 1, 3'd0, LEVEL, 0, 8'h00, 0, 0, "scanB_idle");

    applyStimulus(1, 1, 1, 3'd6, SCANM, 1, oh(6), 1, 0, "abortB_0");
    applyStimulus(1, 1, 1, 3'd0, LEVEL, 0, oh(6), 1, 0, "abortB_1");
    applyStimulus(1, 1, 1, 3'd0, LEVEL, 0, oh(7), 1, 0, "abortB_2");
    applyStimulus(1, 1, 0, 3'd0, LEVEL, 0, 8'h00, 0, 0, "abortB");
    applyStimulus(1, 1, 0, 3'd0, LEVEL, 0, 8'h00, 0, 0, "abortB_idle");
    applyStimulus(1, 1, 1, 3'd5, LEVEL, 0, oh(5), 0, 0, "levelB");

    repeat (10) begin
      if (sbQ.size() == 0) break;
      @(negedge clk);
    end
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sbQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
